// File: rtl/ov5640_capture_pkg.sv
// Shared definitions for the OV5640 DVP capture stage: FSM encoding and the
// default counter width and window geometry.
package ov5640_capture_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SKIP = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam int DEF_CNT_W   = 12;
    localparam int DEF_H_START = 0;
    localparam int DEF_H_SIZE  = 640;
    localparam int DEF_V_START = 0;
    localparam int DEF_V_SIZE  = 480;

endpackage

// File: rtl/ov5640_pix_pack.sv
// Assembles PIX_BYTES consecutive camera beats into one pixel word, with
// optional byte reversal, and reports a partially assembled pixel.
module ov5640_pix_pack #(
    parameter int IN_W      = 8,
    parameter int PIX_BYTES = 2
) (
    input  logic                      ov5640_pclk,
    input  logic                      sys_rst_n,
    input  logic                      href_d,
    input  logic                      href_rise,
    input  logic                      clear,
    input  logic [IN_W-1:0]           data_d,
    input  logic                      byte_swap,
    output logic                      pix_valid,
    output logic [IN_W*PIX_BYTES-1:0] pix_data,
    output logic                      partial
);

    localparam int OUT_W  = IN_W * PIX_BYTES;
    localparam int BEAT_W = (PIX_BYTES > 1) ? $clog2(PIX_BYTES) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PIX_BYTES - 1);

    logic [BEAT_W-1:0] beat_cnt;
    logic [BEAT_W-1:0] cur_beat;
    logic [BEAT_W-1:0] slot;
    logic [OUT_W-1:0]  acc;
    logic [OUT_W-1:0]  acc_next;
    logic              last_beat;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        cur_beat  = href_rise ? '0 : beat_cnt;
        slot      = byte_swap ? cur_beat : BEAT_LAST - cur_beat;
        last_beat = (cur_beat == BEAT_LAST);
        acc_next  = acc;
        acc_next[int'(slot)*IN_W +: IN_W] = data_d;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            beat_cnt  <= '0;
            acc       <= '0;
            pix_valid <= 1'b0;
        end else begin
            pix_valid <= 1'b0;
            if (clear) begin
                beat_cnt <= '0;
            end else if (href_d) begin
                acc       <= acc_next;
                beat_cnt  <= last_beat ? '0 : cur_beat + 1'b1;
                pix_valid <= last_beat;
            end
        end
    end

    // Every slot is rewritten per pixel, so acc holds the finished word while pix_valid is high.
    assign pix_data = acc;
    assign partial  = (beat_cnt != '0);

endmodule

// File: rtl/ov5640_capture.sv
// OV5640 DVP capture: input registers, frame-skip FSM, pixel/line counters,
// window crop and boundary-tagged pixel output, all in the pixel-clock domain.
module ov5640_capture
    import ov5640_capture_pkg::*;
#(
    parameter int IN_W       = 8,
    parameter int PIX_BYTES  = 2,
    parameter int FRAME_SKIP = 10,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int H_START    = DEF_H_START,
    parameter int H_SIZE     = DEF_H_SIZE,
    parameter int V_START    = DEF_V_START,
    parameter int V_SIZE     = DEF_V_SIZE
) (
    input  logic                      ov5640_pclk,
    input  logic                      sys_rst_n,
    input  logic                      ov5640_vsync,
    input  logic                      ov5640_href,
    input  logic [IN_W-1:0]           ov5640_data,
    input  logic                      cap_en,
    input  logic                      byte_swap,
    output logic                      cap_wr_en,
    output logic [IN_W*PIX_BYTES-1:0] cap_data,
    output logic                      cap_sof,
    output logic                      cap_eol,
    output logic                      cap_eof,
    output logic                      line_err,
    output logic [15:0]               frame_cnt
);

    localparam int OUT_W  = IN_W * PIX_BYTES;
    localparam int SKIP_W = (FRAME_SKIP > 1) ? $clog2(FRAME_SKIP) : 1;
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(FRAME_SKIP - 1);
    localparam logic [CNT_W:0]    H_LO   = (CNT_W+1)'(H_START);
    localparam logic [CNT_W:0]    H_SZ   = (CNT_W+1)'(H_SIZE);
    localparam logic [CNT_W:0]    H_END  = (CNT_W+1)'(H_START + H_SIZE);
    localparam logic [CNT_W:0]    V_LO   = (CNT_W+1)'(V_START);
    localparam logic [CNT_W:0]    V_SZ   = (CNT_W+1)'(V_SIZE);
    localparam logic [CNT_W-1:0]  H_LAST = CNT_W'(H_START + H_SIZE - 1);
    localparam logic [CNT_W-1:0]  V_LAST = CNT_W'(V_START + V_SIZE - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    if ((H_START + H_SIZE > 2**CNT_W) || (V_START + V_SIZE > 2**CNT_W) ||
        (PIX_BYTES < 1) || (PIX_BYTES > 4)) begin : g_param_err
        $error("ov5640_capture: window exceeds counter range or PIX_BYTES outside 1..4");
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    logic              vsync_d, vsync_dd, href_d, href_dd;
    logic [IN_W-1:0]   data_d;
    logic              vsync_rise, href_rise, href_fall;
    state_t            state, state_next;
    logic [SKIP_W-1:0] skip_cnt, skip_next;
    logic [CNT_W-1:0]  x_cnt, y_cnt;
    logic [CNT_W:0]    x_off, y_off, x_done;
    logic              line_active, sof_pending;
    logic              pix_valid, partial;
    logic [OUT_W-1:0]  pix_data;
    logic              x_in, y_in, emit, eol_now, eof_now, err_now;

    always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vsync_d  <= 1'b0;
            vsync_dd <= 1'b0;
            href_d   <= 1'b0;
            href_dd  <= 1'b0;
            data_d   <= '0;
        end else begin
            vsync_d  <= ov5640_vsync;
            vsync_dd <= vsync_d;
            href_d   <= ov5640_href;
            href_dd  <= href_d;
            data_d   <= ov5640_data;
        end
    end

    assign vsync_rise = vsync_d & ~vsync_dd;
    assign href_rise  = href_d & ~href_dd;
    assign href_fall  = ~href_d & href_dd;

    ov5640_pix_pack #(
        .IN_W      (IN_W),
        .PIX_BYTES (PIX_BYTES)
    ) u_pix_pack (
        .ov5640_pclk (ov5640_pclk),
        .sys_rst_n   (sys_rst_n),
        .href_d      (href_d),
        .href_rise   (href_rise),
        .clear       (vsync_rise),
        .data_d      (data_d),
        .byte_swap   (byte_swap),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .partial     (partial)
    );

    always_comb begin
        state_next = state;
        skip_next  = skip_cnt;
        if (vsync_rise) begin
            unique case (state)
                S_IDLE: if (cap_en) begin
                    state_next = (FRAME_SKIP > 0) ? S_SKIP : S_RUN;
                    skip_next  = '0;
                end
                S_SKIP: begin
                    if (!cap_en)                   state_next = S_IDLE;
                    else if (skip_cnt == SKIP_LAST) state_next = S_RUN;
                    skip_next = skip_cnt + 1'b1;
                end
                S_RUN:   if (!cap_en) state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= S_IDLE;
            skip_cnt <= '0;
        end else begin
            state    <= state_next;
            skip_cnt <= skip_next;
        end
    end

    // Offset compares: a coordinate below the window start wraps past the window size.
    assign x_off   = {1'b0, x_cnt} - H_LO;
    assign y_off   = {1'b0, y_cnt} - V_LO;
    assign x_in    = (x_off < H_SZ);
    assign y_in    = (y_off < V_SZ);
    assign x_done  = {1'b0, pix_valid ? sat_inc(x_cnt) : x_cnt};
    assign emit    = pix_valid && line_active && (state == S_RUN) && x_in && y_in && !vsync_rise;
    assign eol_now = emit && (x_cnt == H_LAST);
    assign eof_now = eol_now && (y_cnt == V_LAST);
    assign err_now = (state == S_RUN) && href_fall && line_active && y_in &&
                     (partial || (x_done < H_END));

    // A vsync rise mid-line drops line_active, so the aborted line neither emits nor counts.
    always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            x_cnt       <= '0;
            y_cnt       <= '0;
            line_active <= 1'b0;
            sof_pending <= 1'b0;
        end else if (vsync_rise) begin
            x_cnt       <= '0;
            y_cnt       <= '0;
            line_active <= 1'b0;
            sof_pending <= 1'b1;
        end else begin
            if (href_rise)      x_cnt <= '0;
            else if (pix_valid) x_cnt <= sat_inc(x_cnt);
            if (href_rise)      line_active <= 1'b1;
            else if (href_fall) line_active <= 1'b0;
            if (href_fall && line_active) y_cnt <= sat_inc(y_cnt);
            if (emit)           sof_pending <= 1'b0;
        end
    end

    always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cap_wr_en <= 1'b0;
            cap_data  <= '0;
            cap_sof   <= 1'b0;
            cap_eol   <= 1'b0;
            cap_eof   <= 1'b0;
            line_err  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            cap_wr_en <= emit;
            cap_sof   <= emit && sof_pending;
            cap_eol   <= eol_now;
            cap_eof   <= eof_now;
            line_err  <= err_now;
            if (emit)    cap_data  <= pix_data;
            if (eof_now) frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule
